// File: rtl/exmem_stage.sv
// exmem_stage: EX/MEM pipeline register with valid/ready flow control, synchronous flush and forwarding port.
// Define EXMEM_SKID_EN to add a skid entry so in_ready_o comes from a flop instead of out_ready_i.
module exmem_stage #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5,
    parameter int CTRL_WIDTH             = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              flush_i,
    input  logic [CTRL_WIDTH-1:0]             ctrl_i,
    input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
    input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [CTRL_WIDTH-1:0]             ctrl_o,
    output logic [PROC_DATA_WIDTH-1:0]        alu_o,
    output logic [PROC_DATA_WIDTH-1:0]        reg_data2_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
    output logic                              fwd_valid_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] fwd_addr_o,
    output logic [PROC_DATA_WIDTH-1:0]        fwd_data_o,
    output logic [1:0]                        occupancy_o
);
    localparam int EW = CTRL_WIDTH + 2 * PROC_DATA_WIDTH + PROC_REGFILE_LOG2_DEEP;

    logic [EW-1:0]         w_in_ent, r_m_ent, w_m_ent_nxt;
    logic                  r_m_valid, w_m_valid_nxt, w_accept, w_drain;
    logic [CTRL_WIDTH-1:0] w_ctrl;

    assign w_in_ent = {ctrl_i, alu_i, reg_data2_i, reg_write_addr_i};
    assign w_accept = in_valid_i & in_ready_o & ~flush_i;
    assign w_drain  = r_m_valid & out_ready_i;

`ifdef EXMEM_SKID_EN
    logic [EW-1:0] r_s_ent;
    logic          r_s_valid, w_s_load;

    // Skid only fills while main is stuck; in_ready_o blocks a second write.
    assign in_ready_o = ~r_s_valid;
    assign w_s_load   = w_accept & r_m_valid & ~w_drain;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_ent_nxt   = r_m_ent;
        if (flush_i) begin
            w_m_valid_nxt = 1'b0;
        end else if (w_drain & r_s_valid) begin
            w_m_valid_nxt = 1'b1;
            w_m_ent_nxt   = r_s_ent;
        end else if (w_accept & (~r_m_valid | w_drain)) begin
            w_m_valid_nxt = 1'b1;
            w_m_ent_nxt   = w_in_ent;
        end else if (w_drain) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s_valid <= 1'b0;
            r_s_ent   <= '0;
        end else begin
            if (flush_i)
                r_s_valid <= 1'b0;
            else if (w_s_load)
                r_s_valid <= 1'b1;
            else if (w_drain)
                r_s_valid <= 1'b0;
            if (w_s_load)
                r_s_ent <= w_in_ent;
        end
    end

    assign occupancy_o = {r_m_valid & r_s_valid, r_m_valid ^ r_s_valid};
`else
    assign in_ready_o = ~r_m_valid | out_ready_i;

    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_ent_nxt   = r_m_ent;
        if (flush_i) begin
            w_m_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_m_valid_nxt = 1'b1;
            w_m_ent_nxt   = w_in_ent;
        end else if (w_drain) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    assign occupancy_o = {1'b0, r_m_valid};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_valid <= 1'b0;
            r_m_ent   <= '0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_m_ent   <= w_m_ent_nxt;
        end
    end

    assign {w_ctrl, alu_o, reg_data2_o, reg_write_addr_o} = r_m_ent;
    assign out_valid_o = r_m_valid;
    // Bubbles carry zero control so downstream write enables stay low.
    assign ctrl_o      = r_m_valid ? w_ctrl : '0;
    assign fwd_valid_o = r_m_valid & ctrl_o[0] & ~ctrl_o[2];
    assign fwd_addr_o  = reg_write_addr_o;
    assign fwd_data_o  = alu_o;
endmodule

// File: tb/tb_exmem_stage.sv
// tb_exmem_stage: randomized check of exmem_stage against a FIFO-queue reference model.
// Honours EXMEM_SKID_EN to select the two-entry or one-entry model.
module tb_exmem_stage;
    typedef struct packed {
        logic [3:0]  c;
        logic [15:0] a;
        logic [15:0] d;
        logic [4:0]  r;
    } ent_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [15:0] alu = '0, d2 = '0;
    logic [4:0]  addr = '0;
    logic        in_ready, out_valid, fwd_valid;
    logic [3:0]  ctrl_o;
    logic [15:0] alu_o, d2_o, fwd_data;
    logic [4:0]  addr_o, fwd_addr;
    logic [1:0]  occ;

    int   vectors = 0, miscompares = 0;
    ent_t q[$];

    exmem_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .flush_i(flush), .ctrl_i(ctrl), .alu_i(alu), .reg_data2_i(d2),
        .reg_write_addr_i(addr), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ctrl_o(ctrl_o), .alu_o(alu_o), .reg_data2_o(d2_o), .reg_write_addr_o(addr_o),
        .fwd_valid_o(fwd_valid), .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data),
        .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
`ifdef EXMEM_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || out_ready;
`endif
    endfunction

    // Reference: a FIFO of capacity 1 or 2 that pops on drain and pushes on accept.
    always @(posedge clk) begin
        bit acc, dr;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && m_ready();
            dr  = q.size() > 0 && out_ready;
            if (dr) void'(q.pop_front());
            if (acc) q.push_back('{c: ctrl, a: alu, d: d2, r: addr});
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        ent_t e;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_ctrl", 32'(ctrl_o), 0);
            chk("rst_alu", 32'(alu_o), 0);
            chk("rst_d2", 32'(d2_o), 0);
            chk("rst_addr", 32'(addr_o), 0);
            chk("rst_occ", 32'(occ), 0);
            chk("rst_fwd_valid", 32'(fwd_valid), 0);
            return;
        end
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("occupancy", 32'(occ), 32'(q.size()));
        if (q.size() > 0) begin
            e = q[0];
            chk("ctrl_o", 32'(ctrl_o), 32'(e.c));
            chk("alu_o", 32'(alu_o), 32'(e.a));
            chk("reg_data2_o", 32'(d2_o), 32'(e.d));
            chk("reg_write_addr_o", 32'(addr_o), 32'(e.r));
            chk("fwd_valid", 32'(fwd_valid), 32'(e.c[0] && !e.c[2]));
            chk("fwd_addr", 32'(fwd_addr), 32'(e.r));
            chk("fwd_data", 32'(fwd_data), 32'(e.a));
        end else begin
            chk("bubble_ctrl", 32'(ctrl_o), 0);
            chk("bubble_fwd", 32'(fwd_valid), 0);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sample();
        sample();
        edge_();
        rst_n = 1'b1;
        sample();
        chk("ready_after_reset", 32'(in_ready), 1);
        edge_();

        // single entry, one-cycle latency
        in_valid = 1'b1; ctrl = 4'b0001; alu = 16'h1234; d2 = 16'h0bad; addr = 5'd3; out_ready = 1'b1;
        sample();
        edge_();
        in_valid = 1'b0;
        sample();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_alu", 32'(alu_o), 32'h1234);
        chk("t1_fwd_valid", 32'(fwd_valid), 1);
        chk("t1_fwd_addr", 32'(fwd_addr), 3);
        edge_();
        sample();
        chk("t1_leave", 32'(out_valid), 0);
        edge_();

        // full-rate stream
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; alu = 16'(i); ctrl = 4'b0001; addr = 5'(i + 1);
            sample();
            chk("stream_ready", 32'(in_ready), 1);
            if (i > 0) chk("stream_alu", 32'(alu_o), 32'(i - 1));
            edge_();
        end
        in_valid = 1'b0;
        sample();
        chk("stream_last", 32'(alu_o), 7);
        edge_();

        // back-pressure: A, B held, C waits
        out_ready = 1'b0; in_valid = 1'b1; alu = 16'hA;
        sample(); edge_();
        alu = 16'hB;
        sample(); edge_();
        alu = 16'hC;
        sample();
`ifdef EXMEM_SKID_EN
        chk("skid_occ", 32'(occ), 2);
        chk("skid_ready", 32'(in_ready), 0);
`endif
        edge_();
        sample(); edge_();
        out_ready = 1'b1;
        sample();
`ifdef EXMEM_SKID_EN
        chk("skid_A", 32'(alu_o), 32'hA);
`endif
        edge_();
        sample();
`ifdef EXMEM_SKID_EN
        chk("skid_B", 32'(alu_o), 32'hB);
`endif
        edge_();
        in_valid = 1'b0;
        sample();
        chk("skid_C", 32'(alu_o), 32'hC);
        edge_();
        sample(); edge_();

        // flush with held entries and a live input
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 4'b1001; alu = 16'h11;
        sample(); edge_();
        alu = 16'h22;
        sample(); edge_();
        alu = 16'h33; flush = 1'b1;
        sample(); edge_();
        flush = 1'b0; in_valid = 1'b0;
        sample();
        chk("flush_occ", 32'(occ), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ctrl", 32'(ctrl_o), 0);
        edge_();
        out_ready = 1'b1;
        repeat (3) begin
            sample();
            chk("flush_gone", 32'(out_valid), 0);
            edge_();
        end

        // load entry is not forwardable
        out_ready = 1'b0; in_valid = 1'b1; ctrl = 4'b1101; alu = 16'h55; addr = 5'd9;
        sample(); edge_();
        in_valid = 1'b0;
        sample();
        chk("load_valid", 32'(out_valid), 1);
        chk("load_fwd", 32'(fwd_valid), 0);
        edge_();

        // asynchronous reset mid-stream
        out_ready = 1'b1; in_valid = 1'b1; ctrl = 4'b0001; alu = 16'h77; d2 = 16'h88; addr = 5'd12;
        sample(); edge_();
        sample(); edge_();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ctrl", 32'(ctrl_o), 0);
        chk("arst_alu", 32'(alu_o), 0);
        chk("arst_d2", 32'(d2_o), 0);
        chk("arst_addr", 32'(addr_o), 0);
        chk("arst_occ", 32'(occ), 0);
        chk("arst_fwd", 32'(fwd_valid), 0);
        in_valid = 1'b0;
        sample(); edge_();
        rst_n = 1'b1;

        // randomized traffic
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            ctrl      = 4'($urandom);
            alu       = 16'($urandom);
            d2        = 16'($urandom);
            addr      = 5'($urandom);
            sample();
            edge_();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            sample(); edge_();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/exmem_stage.md
# exmem_stage

Parametrised EX/MEM pipeline stage register that replaces the fixed, always-advancing EX/MEM latch. It carries the packed control bits, the ALU result, the store data and the destination register address from EX to MEM. It adds valid/ready flow control, a synchronous flush and an optional two-entry skid buffer, so MEM-side back-pressure from a slow data memory does not combinationally stall EX. It also drives a forwarding port that lets EX bypass from the MEM-bound result.

## Interface
- PROC_DATA_WIDTH, 16, width of the ALU result and the store data
- PROC_REGFILE_LOG2_DEEP, 5, width of the register address
- CTRL_WIDTH, 4, packed control width; bit 0 reg_write_en, bit 1 mem_write_en, bit 2 mem_read_en, bit 3 mem_to_reg; any further bits pass through untouched

Ports:
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  EX presents a valid entry
- in_ready_o  out  1  stage can accept an entry this cycle
- flush_i  in  1  synchronous kill of all held entries and of the current input
- ctrl_i  in  CTRL_WIDTH  packed control from EX
- alu_i  in  PROC_DATA_WIDTH  ALU result
- reg_data2_i  in  PROC_DATA_WIDTH  store data
- reg_write_addr_i  in  PROC_REGFILE_LOG2_DEEP  destination register
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  MEM consumes the output entry
- ctrl_o  out  CTRL_WIDTH  control of the output entry; all zero when out_valid_o=0
- alu_o, reg_data2_o  out  PROC_DATA_WIDTH  output entry data
- reg_write_addr_o  out  PROC_REGFILE_LOG2_DEEP  output entry destination
- fwd_valid_o  out  1  out_valid_o & ctrl_o[0] & ~ctrl_o[2]
- fwd_addr_o  out  PROC_REGFILE_LOG2_DEEP  equals reg_write_addr_o
- fwd_data_o  out  PROC_DATA_WIDTH  equals alu_o
- occupancy_o  out  2  number of valid entries held (0..2)

## Operation
- Storage: an output entry (main) and, with the skid buffer enabled, one skid entry. Each entry holds ctrl, alu, data2, addr and a valid bit.
- Accept: in_valid_i & in_ready_o & ~flush_i.
- Drain: out_valid_o & out_ready_i.
- Main entry:
  - On drain, main loads the skid entry if one is valid, otherwise the accepted input, otherwise goes invalid.
  - If main is empty or draining and no skid entry is valid, main takes the accepted input directly.
- Skid entry (skid build only):
  - Loads the accepted input when main is valid and not draining.
  - Clears when its contents move to main.
  - Skid is never written while it is already valid.
- Flush:
  - Clears all valid bits at the next edge.
  - Takes priority over a simultaneous accept and a simultaneous drain; the input presented in the flush cycle is discarded.
  - Data fields keep their old values; only the valid bits and the ctrl gating change.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush.
- Bubbles: ctrl_o is forced to zero when invalid, so MEM and WB write enables never assert for a bubble.
- Widths: all data is passed through bit-exact, with no sign or zero extension.

## Timing
- Reset: while rst_ni=0, all valid bits are 0, ctrl_o=0, alu_o=0, reg_data2_o=0, reg_write_addr_o=0, occupancy_o=0, fwd_valid_o=0. in_ready_o=1 after reset.
- Latency: exactly one cycle from accept to out_valid_o when the stage is empty.
- Throughput: one entry per cycle while out_ready_i=1.
- in_ready_o: combinational in the non-skid build, registered in the skid build (see Configuration).
- Reset asserted mid-operation drops all entries immediately, asynchronously.
- Simultaneous accept and drain with occupancy 1: occupancy stays 1 and main is replaced by the new input.

## Configuration
- EXMEM_SKID_EN defined:
  - The skid entry exists.
  - in_ready_o = ~skid_valid, driven from a flop with no combinational path from out_ready_i.
  - occupancy_o ranges 0..2.
- EXMEM_SKID_EN undefined:
  - Main entry only.
  - in_ready_o = ~out_valid_o | out_ready_i, a combinational path.
  - occupancy_o ranges 0..1.
  - Behaviour otherwise identical.

## Test plan
- Reset release, then one entry in (ctrl=4'b0001, alu=16'h1234, addr=5'd3), out_ready_i=1 -> out_valid_o=1 one cycle later with alu_o=16'h1234, fwd_valid_o=1, fwd_addr_o=3. The entry leaves the next cycle.
- Stream of 8 entries (alu=0..7) with out_ready_i=1 -> 8 consecutive outputs 0..7 and in_ready_o stays 1 throughout.
- (skid build) Hold out_ready_i=0 while sending entries A=16'hA, B=16'hB, C=16'hC -> A and B accepted, occupancy_o=2, in_ready_o=0, C held off. Releasing out_ready_i then yields A, B, C in order.
- flush_i=1 with occupancy 2 and in_valid_i=1 -> next cycle occupancy_o=0, out_valid_o=0, ctrl_o=0, and the flushed input never appears at the output.
- Load entry (ctrl=4'b1101) -> fwd_valid_o=0 while valid. Assert rst_ni=0 mid-stream -> all outputs go to their reset values without waiting for a clock edge.
